// File: rtl/capture_trigger_writer.sv
// rtl/capture_trigger_writer.sv - triggered I/Q capture into a buffer over an AXI-style write channel
module capture_trigger_writer #(
    parameter int buffer_length  = 10,
    parameter int capture_length = 10,
    parameter int index_bits     = 4,
    parameter int i_bits         = 12,
    parameter int q_bits         = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       force_trigger,
    input  logic                       trig_en,
    input  logic [i_bits:0]            threshold,
    input  logic                       sample_valid,
    input  logic [i_bits-1:0]          i_in,
    input  logic [q_bits-1:0]          q_in,
    output logic [index_bits-1:0]      m_axi_waddr,
    output logic                       m_axi_wvalid,
    output logic [i_bits+q_bits-1:0]   m_axi_wdata,
    input  logic                       s_axi_wready,
    input  logic                       s_axi_bvalid,
    input  logic                       s_axi_bresp,
    output logic                       m_axi_bready,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic                       error
);
    localparam int m_bits   = i_bits + 1;
    localparam int cnt_bits = $clog2(capture_length + 1);
    localparam logic [index_bits-1:0] last_addr = index_bits'(capture_length - 1);
    localparam logic [cnt_bits-1:0]   cap_len   = cnt_bits'(capture_length);

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

    state_t                state, state_next;
    logic [index_bits-1:0] ptr;
    logic [cnt_bits-1:0]   issued;
    logic [cnt_bits-1:0]   resp_cnt, resp_next;

    // Sign-extend by one bit first so that |-2^(i_bits-1)| stays exact.
    logic [m_bits-1:0] i_ext, q_ext, abs_i, abs_q, mag;
    logic              trig;

    assign i_ext = {i_in[i_bits-1], i_in};
    assign q_ext = {{(m_bits-q_bits){q_in[q_bits-1]}}, q_in};
    assign abs_i = i_in[i_bits-1] ? (m_bits'(0) - i_ext) : i_ext;
    assign abs_q = q_in[q_bits-1] ? (m_bits'(0) - q_ext) : q_ext;
    assign mag   = abs_i + abs_q;
    assign trig  = sample_valid & (force_trigger | (trig_en & (mag >= threshold)));

    logic fire, count_resp, clear, accept, drop;

    assign fire       = m_axi_wvalid & s_axi_wready;
    assign count_resp = s_axi_bvalid & ((state == CAPTURE) | (state == DRAIN));
    assign resp_next  = resp_cnt + cnt_bits'(count_resp);
    assign busy       = (state == ARMED) | (state == CAPTURE) | (state == DRAIN);
    assign done       = (state == DONE);

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (arm) begin
                    state_next = ARMED;
                    clear      = 1'b1;
                end
            end
            ARMED: begin
                if (trig) begin
                    state_next = CAPTURE;
                    accept     = 1'b1;
                end
            end
            CAPTURE: begin
                // Once every address has been issued, trailing samples are ignored.
                if (sample_valid && (issued != cap_len)) begin
                    if (m_axi_wvalid && !s_axi_wready) drop = 1'b1;
                    else                                accept = 1'b1;
                end
                if (fire && (m_axi_waddr == last_addr)) state_next = DRAIN;
            end
            DRAIN: begin
                if (resp_next == cap_len) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            issued       <= '0;
            resp_cnt     <= '0;
            m_axi_waddr  <= '0;
            m_axi_wdata  <= '0;
            m_axi_wvalid <= 1'b0;
            m_axi_bready <= 1'b0;
            overflow     <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_next;
            m_axi_bready <= 1'b1;
            if (clear) begin
                ptr          <= '0;
                issued       <= '0;
                resp_cnt     <= '0;
                m_axi_waddr  <= '0;
                m_axi_wvalid <= 1'b0;
                overflow     <= 1'b0;
                error        <= 1'b0;
            end else begin
                if (fire) ptr <= ptr + index_bits'(fire);
                if (accept) begin
                    m_axi_wvalid <= 1'b1;
                    m_axi_waddr  <= ptr + index_bits'(fire);
                    m_axi_wdata  <= {i_in, q_in};
                    issued       <= issued + cnt_bits'(1);
                end else if (fire) begin
                    m_axi_wvalid <= 1'b0;
                end
                if (drop) overflow <= 1'b1;
                if (count_resp) begin
                    resp_cnt <= resp_next;
                    if (s_axi_bresp) error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_capture_trigger_writer.sv
// tb/tb_capture_trigger_writer.sv - self-checking bench for capture_trigger_writer
module tb_capture_trigger_writer;
    localparam int CL = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0, force_trigger = 1'b0, trig_en = 1'b0;
    logic [12:0] threshold = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] i_in = '0, q_in = '0;
    logic [3:0]  m_axi_waddr;
    logic        m_axi_wvalid;
    logic [23:0] m_axi_wdata;
    logic        s_axi_wready = 1'b1, s_axi_bvalid = 1'b0, s_axi_bresp = 1'b0;
    logic        m_axi_bready, busy, done, overflow, error;

    capture_trigger_writer dut (
        .clk(clk), .rst(rst), .arm(arm), .force_trigger(force_trigger), .trig_en(trig_en),
        .threshold(threshold), .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
        .m_axi_waddr(m_axi_waddr), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
        .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp),
        .m_axi_bready(m_axi_bready), .busy(busy), .done(done), .overflow(overflow), .error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int i, input int q);
        logic [11:0] a, b;
        a = i[11:0];
        b = q[11:0];
        return {a, b};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Buffer-side responder: answers each accepted write one cycle later and logs it.
    logic [27:0] wlog[$];
    int          wcyc[$];
    int          cyc = 0, bcount = 0, err_at = 0;
    always @(posedge clk) begin
        bit f;
        cyc++;
        f = m_axi_wvalid && s_axi_wready && !rst;
        if (f) begin
            wlog.push_back({m_axi_waddr, m_axi_wdata});
            wcyc.push_back(cyc);
        end
        #2;
        s_axi_bvalid = f;
        s_axi_bresp  = f && (bcount + 1 == err_at);
        if (f) bcount++;
    end

    // Reference model: mode 0 idle, 1 armed, 2 capture, 3 drain, 4 done.
    // The write address is simply the number of samples already taken.
    int          m_mode = 0, m_resp = 0, m_n = 0;
    bit          m_wvalid = 0, m_ovf = 0, m_err = 0, m_bready = 0;
    logic [3:0]  m_waddr = '0;
    logic [23:0] m_wdata = '0;

    always @(posedge clk) begin
        int mag;
        bit trig, fire;
        if (rst) begin
            m_mode = 0; m_resp = 0; m_n = 0;
            m_wvalid = 0; m_ovf = 0; m_err = 0; m_bready = 0;
            m_waddr = '0; m_wdata = '0;
        end else begin
            m_bready = 1;
            mag  = iabs(int'($signed(i_in))) + iabs(int'($signed(q_in)));
            trig = sample_valid && (force_trigger || (trig_en && mag >= int'(threshold)));
            fire = m_wvalid && s_axi_wready;
            if (s_axi_bvalid && (m_mode == 2 || m_mode == 3)) begin
                m_resp++;
                if (s_axi_bresp) m_err = 1;
            end
            case (m_mode)
                0, 4: if (arm) begin
                    m_mode = 1; m_resp = 0; m_n = 0; m_ovf = 0; m_err = 0; m_wvalid = 0;
                end
                1: if (trig) begin
                    m_mode = 2; m_wvalid = 1; m_waddr = 0; m_wdata = {i_in, q_in}; m_n = 1;
                end
                2: begin
                    if (fire && m_waddr == 4'(CL - 1)) m_mode = 3;
                    if (sample_valid && m_n < CL) begin
                        if (m_wvalid && !s_axi_wready) m_ovf = 1;
                        else begin
                            m_wvalid = 1; m_waddr = 4'(m_n); m_wdata = {i_in, q_in}; m_n++;
                        end
                    end else if (fire) m_wvalid = 0;
                end
                3: if (m_resp == CL) m_mode = 4;
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("wvalid", m_axi_wvalid, m_wvalid);
        chk("busy", busy, (m_mode >= 1 && m_mode <= 3));
        chk("done", done, (m_mode == 4));
        chk("overflow", overflow, m_ovf);
        chk("error", error, m_err);
        chk("bready", m_axi_bready, m_bready);
        if (m_wvalid) begin
            chk("waddr", m_axi_waddr, m_waddr);
            chk("wdata", m_axi_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic samp(input int i, input int q);
        sample_valid = 1; i_in = i[11:0]; q_in = q[11:0];
        tick();
    endtask

    task automatic wait_done(input string name);
        sample_valid = 0;
        for (int n = 0; n < 40 && !done; n++) tick();
        chk(name, done, 1);
    endtask

    task automatic start(input bit frc);
        wlog.delete(); wcyc.delete();
        force_trigger = frc; arm = 1; sample_valid = 0;
        tick();
        arm = 0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_waddr", m_axi_waddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        chk("rst_status", {busy, done, overflow, error, m_axi_bready}, 0);
        rst = 0;
        tick();
        chk("bready_after_rst", m_axi_bready, 1);

        // Forced trigger, one write per cycle.
        start(1);
        for (int k = 0; k < CL; k++) samp(k, -k);
        force_trigger = 0;
        wait_done("t1_done");
        chk("t1_busy", busy, 0);
        chk("t1_nwrites", wlog.size(), CL);
        for (int k = 0; k < CL && k < wlog.size(); k++) begin
            chk("t1_write", wlog[k], {4'(k), pk(k, -k)});
            chk("t1_cycle", wcyc[k] - wcyc[0], k);
        end

        // Magnitude trigger, re-armed from DONE.
        trig_en = 1; threshold = 13'd100;
        start(0);
        chk("t2_rearm_done", done, 0);
        samp(10, 20);
        chk("t2_no_trig", m_axi_wvalid, 0);
        samp(-60, -50);
        samp(5, 5);
        for (int k = 1; k <= 8; k++) samp(k, k);
        wait_done("t2_done");
        trig_en = 0;
        chk("t2_nwrites", wlog.size(), CL);
        if (wlog.size() >= 2) begin
            chk("t2_first", wlog[0], {4'd0, pk(-60, -50)});
            chk("t2_second", wlog[1], {4'd1, pk(5, 5)});
        end

        // Stall with samples dropped.
        start(1);
        for (int k = 0; k < 14; k++) begin
            s_axi_wready = !(k == 3 || k == 4);
            samp(k, k);
            if (k == 4) begin
                chk("t3_hold_addr", m_axi_waddr, 2);
                chk("t3_hold_data", m_axi_wdata, pk(2, 2));
            end
        end
        s_axi_wready = 1; force_trigger = 0;
        wait_done("t3_done");
        chk("t3_overflow", overflow, 1);
        chk("t3_nwrites", wlog.size(), CL);
        for (int a = 0; a < CL && a < wlog.size(); a++)
            chk("t3_write", wlog[a], {4'(a), (a < 3) ? pk(a, a) : pk(a + 2, a + 2)});

        // Error response; arm coincides with a trigger-worthy sample in DONE.
        wlog.delete(); wcyc.delete();
        bcount = 0; err_at = 4;
        force_trigger = 1; arm = 1; samp(77, 77);
        arm = 0;
        chk("t4_flags_cleared", {overflow, error, done}, 0);
        for (int k = 0; k < CL; k++) samp(k, -k);
        force_trigger = 0;
        wait_done("t4_done");
        chk("t4_error", error, 1);
        if (wlog.size() >= 1) chk("t4_first", wlog[0], {4'd0, pk(0, 0)});
        chk("t4_nwrites", wlog.size(), CL);
        err_at = 0;

        // Extreme magnitude at the threshold boundary.
        trig_en = 1; threshold = 13'd4096;
        start(0);
        chk("t5_rearm", {done, error, busy}, 3'b001);
        samp(-2048, -2047);
        chk("t5_below", m_axi_wvalid, 0);
        samp(-2048, -2048);
        chk("t5_trig", m_axi_wvalid, 1);
        chk("t5_addr", m_axi_waddr, 0);
        chk("t5_data", m_axi_wdata, 24'h800800);
        for (int k = 1; k < CL; k++) samp(k, k);
        wait_done("t5_done");
        trig_en = 0;

        // Reset in the middle of a capture.
        start(1);
        for (int k = 0; k < 4; k++) samp(k, k);
        rst = 1;
        samp(9, 9);
        chk("t6_wvalid", m_axi_wvalid, 0);
        chk("t6_waddr", m_axi_waddr, 0);
        chk("t6_wdata", m_axi_wdata, 0);
        chk("t6_status", {busy, done, overflow, error, m_axi_bready}, 0);
        rst = 0; sample_valid = 0; force_trigger = 0;
        tick();
        chk("t6_bready", m_axi_bready, 1);
        chk("t6_idle", busy, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
